// File: rtl/restoring_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one conditional subtract per cycle.
// Optional macro RESTORING_DIV_OVERFLOW_CHECK_EN short-circuits divisions whose quotient cannot fit in N bits.
module restoring_div #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      start,
    input  logic [2*DATA_WIDTH-1:0]   in_div_a,
    input  logic [DATA_WIDTH-1:0]     in_div_b,
    output logic                      busy,
    output logic [DATA_WIDTH-1:0]     out_div_quotient,
    output logic [DATA_WIDTH-1:0]     out_div_remainder,
    output logic                      out_div_valid,
    output logic                      out_div_overflow
);

    localparam int N     = DATA_WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [N-1:0]     r_rem;
    logic [N-1:0]     r_dvd;
    logic [N-1:0]     r_divisor;
    logic [N-1:0]     r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf_pend;

    logic [N:0]       w_t;
    logic             w_bit;
    logic [N-1:0]     w_rem_nxt;
    logic [N-1:0]     w_quo_nxt;
    logic             w_ovf;

    // Only R[N-1:0] survives a step, so the subtraction is done modulo 2^N.
    function automatic logic [N:0] cond_sub(input logic [N:0] t, input logic [N-1:0] d);
        if (t >= {1'b0, d})
            return {1'b1, t[N-1:0] - d};
        else
            return {1'b0, t[N-1:0]};
    endfunction

    always_comb begin
        w_t                  = {r_rem, r_dvd[N-1]};
        {w_bit, w_rem_nxt}   = cond_sub(w_t, r_divisor);
        w_quo_nxt            = {r_quo[N-2:0], w_bit};
`ifdef RESTORING_DIV_OVERFLOW_CHECK_EN
        w_ovf                = (in_div_a[2*N-1:N] >= in_div_b);
`else
        w_ovf                = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= IDLE;
            r_rem             <= '0;
            r_dvd             <= '0;
            r_divisor         <= '0;
            r_quo             <= '0;
            r_cnt             <= '0;
            r_ovf_pend        <= 1'b0;
            busy              <= 1'b0;
            out_div_quotient  <= '0;
            out_div_remainder <= '0;
            out_div_valid     <= 1'b0;
            out_div_overflow  <= 1'b0;
        end else if (!enable) begin
            r_state           <= IDLE;
            r_rem             <= '0;
            r_dvd             <= '0;
            r_divisor         <= '0;
            r_quo             <= '0;
            r_cnt             <= '0;
            r_ovf_pend        <= 1'b0;
            busy              <= 1'b0;
            out_div_quotient  <= '0;
            out_div_remainder <= '0;
            out_div_valid     <= 1'b0;
            out_div_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    out_div_valid <= 1'b0;
                    if (start) begin
                        r_divisor <= in_div_b;
                        r_rem     <= in_div_a[2*N-1:N];
                        r_dvd     <= in_div_a[N-1:0];
                        r_quo     <= '0;
                        r_cnt     <= '0;
                        if (w_ovf) begin
                            r_ovf_pend <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_ovf_pend <= 1'b0;
                            busy       <= 1'b1;
                            r_state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_dvd <= {r_dvd[N-2:0], 1'b0};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_STEP) begin
                        busy              <= 1'b0;
                        out_div_quotient  <= w_quo_nxt;
                        out_div_remainder <= w_rem_nxt;
                        out_div_overflow  <= 1'b0;
                        out_div_valid     <= 1'b1;
                        r_state           <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    // An overflow short-cut publishes its result on leaving DONE.
                    if (r_ovf_pend) begin
                        out_div_quotient  <= '0;
                        out_div_remainder <= '0;
                        out_div_overflow  <= 1'b1;
                        out_div_valid     <= 1'b1;
                        r_ovf_pend        <= 1'b0;
                    end else begin
                        out_div_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
